// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of the execute-stage ALU between NUM_REQ requesters.
// One-entry registered response buffer, tagged with the requester index.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]      req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [3:0]                alu_op,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_err
);

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [ID_W-1:0]   r_rsp_id;
  logic              r_rsp_err;
  logic [ID_W-1:0]   r_ptr;

  logic              w_can_issue;
  logic              w_gnt_vld;
  logic [ID_W-1:0]   w_gnt;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic              w_xfer;

  function automatic logic [ID_W-1:0] wrap_idx(
    input logic [ID_W-1:0] base,
    input int              off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  assign w_can_issue = !r_rsp_valid || rsp_ready;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_vld && req_valid[wrap_idx(r_ptr, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = wrap_idx(r_ptr, k);
      end
    end
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (w_gnt_vld) begin
      alu_a  = req_a[int'(w_gnt)*DATA_W +: DATA_W];
      alu_b  = req_b[int'(w_gnt)*DATA_W +: DATA_W];
      alu_op = req_op[int'(w_gnt)*4 +: 4];
    end
  end

  assign w_xfer = w_can_issue && w_gnt_vld && !rst;

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_gnt] = 1'b1;
  end

  assign w_ptr_nxt = (w_gnt == ID_W'(NUM_REQ - 1)) ?
                     '0 : w_gnt + ID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_err   <= 1'b0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= alu_result;
      r_rsp_id    <= w_gnt;
      r_rsp_err   <= (alu_op > 4'd3);
      r_ptr       <= w_ptr_nxt;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;

endmodule
